// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// mips_multicycle_ctrl : multicycle MIPS control sequencer with memory wait
//                        states, illegal-opcode trap and retired-instr counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_TRAP   = 4'd11;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          c_OP_RTYPE:        w_next = S_EXEC;
          c_OP_LW, c_OP_SW:  w_next = S_MEMADR;
          c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
          c_OP_J:            w_next = S_JUMP;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: w_next = (Opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSrc       = 2'b00;
    illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = 3'b001;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = 3'b001;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 3'b001;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b011;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        BranchNe    = (Opcode == c_OP_BNE);
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

  // A store only retires once memory accepts it; the other retiring states are single-cycle.
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                    ((r_state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (w_retire) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// tb_mips_multicycle_ctrl : directed vector bench for the multicycle sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;

  // Control bundle order: PCWrite PCWriteCond BranchNe IorD MemRead MemWrite IRWrite
  // MemtoReg RegDst RegWrite ALUSrcA ALUSrcB[2] ALUOp[3] PCSrc[2] illegal
  localparam logic [18:0] E_IDLE   = 19'd0;
  localparam logic [18:0] E_FETCHW = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b001,2'b00,1'b0};
  localparam logic [18:0] E_FETCHR = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b001,2'b00,1'b0};
  localparam logic [18:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b001,2'b00,1'b0};
  localparam logic [18:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b001,2'b00,1'b0};
  localparam logic [18:0] E_MEMRD  = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [18:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [18:0] E_MEMWR  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [18:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,2'b00,1'b0};
  localparam logic [18:0] E_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [18:0] E_BEQ    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b011,2'b01,1'b0};
  localparam logic [18:0] E_BNE    = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b011,2'b01,1'b0};
  localparam logic [18:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b10,1'b0};
  localparam logic [18:0] E_TRAP   = 19'd1;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  typedef struct {
    logic [5:0]       op;
    logic             rdy;
    logic [3:0]       st;
    logic [18:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       Opcode = 6'd0;
  logic             mem_ready = 1'b1;
  logic             PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0]       ALUSrcB, PCSrc;
  logic [2:0]       ALUOp;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic [18:0]      ctl;

  int errors = 0;
  int checks = 0;
  vec_t vq[$];

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .illegal(illegal), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign ctl = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal};

  task automatic check(input string name, input logic [3:0] st, input logic [18:0] c,
                       input logic [CNT_W-1:0] n);
    checks++;
    if (state !== st || ctl !== c || instr_count !== n) begin
      errors++;
      $display("FAIL %s: state=%0d ctl=%b cnt=%0d, required state=%0d ctl=%b cnt=%0d",
               name, state, ctl, instr_count, st, c, n);
    end
  endtask

  // Entered just after a rising edge: drive inputs, check mid-cycle, advance one edge.
  task automatic step(input string name, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [18:0] c, input logic [CNT_W-1:0] n);
    Opcode    = op;
    mem_ready = rdy;
    @(negedge clk);
    check(name, st, c, n);
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                              input logic [18:0] c, input logic [CNT_W-1:0] n);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctl = c; v.cnt = n;
    vq.push_back(v);
  endfunction

  initial begin
    // R-type
    add(OP_R,   1, 0,  E_IDLE,   0);
    add(OP_R,   1, 1,  E_FETCHR, 0);
    add(OP_R,   1, 2,  E_DECODE, 0);
    add(OP_R,   1, 7,  E_EXEC,   0);
    add(OP_R,   1, 8,  E_ALUWB,  0);
    // LW with two wait cycles in MEMRD
    add(OP_R,   1, 1,  E_FETCHR, 1);
    add(OP_LW,  1, 2,  E_DECODE, 1);
    add(OP_LW,  1, 3,  E_MEMADR, 1);
    add(OP_LW,  0, 4,  E_MEMRD,  1);
    add(OP_LW,  0, 4,  E_MEMRD,  1);
    add(OP_LW,  1, 4,  E_MEMRD,  1);
    add(OP_LW,  1, 5,  E_MEMWB,  1);
    // SW then BNE
    add(OP_LW,  1, 1,  E_FETCHR, 2);
    add(OP_SW,  1, 2,  E_DECODE, 2);
    add(OP_SW,  1, 3,  E_MEMADR, 2);
    add(OP_SW,  1, 6,  E_MEMWR,  2);
    add(OP_SW,  1, 1,  E_FETCHR, 3);
    add(OP_BNE, 1, 2,  E_DECODE, 3);
    add(OP_BNE, 1, 9,  E_BNE,    3);
    // BEQ, fetch with a wait cycle, then J
    add(OP_BNE, 1, 1,  E_FETCHR, 4);
    add(OP_BEQ, 1, 2,  E_DECODE, 4);
    add(OP_BEQ, 1, 9,  E_BEQ,    4);
    add(OP_BEQ, 0, 1,  E_FETCHW, 5);
    add(OP_BEQ, 1, 1,  E_FETCHR, 5);
    add(OP_J,   1, 2,  E_DECODE, 5);
    add(OP_J,   1, 10, E_JUMP,   5);
    // SW with a wait cycle in MEMWR
    add(OP_J,   1, 1,  E_FETCHR, 6);
    add(OP_SW,  1, 2,  E_DECODE, 6);
    add(OP_SW,  1, 3,  E_MEMADR, 6);
    add(OP_SW,  0, 6,  E_MEMWR,  6);
    add(OP_SW,  1, 6,  E_MEMWR,  6);
    add(OP_SW,  1, 1,  E_FETCHR, 7);

    // Reset state
    #2;
    check("reset_hold", 0, E_IDLE, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    // First edge after release already moved IDLE -> FETCH, so the table starts at row 1.
    Opcode = OP_R;
    mem_ready = 1'b1;
    #1;
    check("first_edge_fetch", 1, E_FETCHR, 0);
    for (int i = 1; i < vq.size(); i++) begin
      step($sformatf("vec%0d", i), vq[i].op, vq[i].rdy, vq[i].st, vq[i].ctl, vq[i].cnt);
    end

    // Illegal opcode: absorbing trap, count frozen
    step("trap_decode", OP_BAD, 1, 2, E_DECODE, 7);
    for (int i = 0; i < 12; i++) begin
      step($sformatf("trap_hold%0d", i), OP_BAD, 1'(i % 2), 11, E_TRAP, 7);
    end
    reset = 1'b1;
    #1;
    check("trap_reset_async", 0, E_IDLE, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step("trap_exit_fetch", OP_R, 1, 1, E_FETCHR, 0);

    // Reset mid-MEMWR must abort the store
    step("abort_decode", OP_SW, 1, 2, E_DECODE, 0);
    step("abort_memadr", OP_SW, 1, 3, E_MEMADR, 0);
    step("abort_memwr",  OP_SW, 0, 6, E_MEMWR,  0);
    mem_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("abort_async", 0, E_IDLE, 0);
    @(negedge clk);
    check("abort_hold", 0, E_IDLE, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step("abort_fetch", OP_R, 1, 1, E_FETCHR, 0);

    // 17 jumps wrap the 4-bit counter to 1
    step("wrap_dec0", OP_J, 1, 2, E_DECODE, 0);
    step("wrap_jmp0", OP_J, 1, 10, E_JUMP, 0);
    for (int k = 1; k < 17; k++) begin
      step($sformatf("wrap_fetch%0d", k), OP_J, 1, 1,  E_FETCHR, CNT_W'(k));
      step($sformatf("wrap_dec%0d", k),   OP_J, 1, 2,  E_DECODE, CNT_W'(k));
      step($sformatf("wrap_jmp%0d", k),   OP_J, 1, 10, E_JUMP,   CNT_W'(k));
    end
    step("wrap_final", OP_J, 1, 1, E_FETCHR, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // MemRead/MemWrite exclusivity holds in every sampled cycle.
  always @(negedge clk) begin
    if (MemRead && MemWrite) begin
      errors++;
      checks++;
      $display("FAIL mem_excl: MemRead=%b MemWrite=%b, required not both 1", MemRead, MemWrite);
    end
  end

endmodule

`default_nettype wire
